// File: rtl/hls_tb_pkg.sv
// hls_tb_pkg
//   Shared definitions for the HLS run sequencer: result status codes,
//   FSM state encoding and the default per-run timeout.
package hls_tb_pkg;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd200_000_000;

  // ST_ABORTED is reserved for a future host-abort input; never generated.
  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_TIMEOUT = 2'd1,
    ST_ABORTED = 2'd2
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRST   = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_REPORT = 3'd4,
    S_FINISH = 3'd5
  } state_e;

endpackage

// File: rtl/hls_latency_stats.sv
// hls_latency_stats
//   Min / max / total accumulator over accepted OK-run latencies.
//   Ports:
//     clock, reset   clock, async active-low reset
//     clear          return all statistics to their empty values
//     update         fold sample into the statistics this cycle
//     sample         latency of the run being accepted
//     stat_min       smallest sample, all ones when empty
//     stat_max       largest sample, 0 when empty
//     stat_total     sum of samples; RUN_W extra bits so it cannot wrap
module hls_latency_stats #(
  parameter int CYCLE_W = 32,
  parameter int RUN_W   = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       update,
  input  logic [CYCLE_W-1:0]         sample,
  output logic [CYCLE_W-1:0]         stat_min,
  output logic [CYCLE_W-1:0]         stat_max,
  output logic [CYCLE_W+RUN_W-1:0]   stat_total
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_min   <= '1;
      stat_max   <= '0;
      stat_total <= '0;
    end else if (clear) begin
      stat_min   <= '1;
      stat_max   <= '0;
      stat_total <= '0;
    end else if (update) begin
      if (sample < stat_min) stat_min <= sample;
      if (sample > stat_max) stat_max <= sample;
      stat_total <= stat_total + {{RUN_W{1'b0}}, sample};
    end
  end

endmodule

// File: rtl/hls_run_sequencer.sv
// hls_run_sequencer
//   Multi-run controller for a Bambu-generated accelerator. Each run resets
//   the accelerator, pulses start_port, measures latency up to done_port,
//   enforces a timeout and emits one result record over a valid/ready port.
//   Ports:
//     clock, reset           clock, async active-low reset
//     go, num_runs           batch request (sampled in IDLE only), run count
//     dut_reset              active-low reset to the accelerator
//     dut_start, dut_done    start_port pulse / done_port
//     res_valid, res_ready   result record handshake
//     res_index/status/cycles  record fields (0-based run, status code, latency)
//     busy, batch_done       batch in progress / one-cycle end-of-batch pulse
//     stat_min/max/total     latency statistics over OK runs of the last batch
module hls_run_sequencer
  import hls_tb_pkg::*;
#(
  parameter int          CYCLE_W          = 32,
  parameter int          RUN_W            = 8,
  parameter int unsigned TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES,
  parameter int          RST_CYCLES       = 2,
  parameter bit          ABORT_ON_TIMEOUT = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     go,
  input  logic [RUN_W-1:0]         num_runs,
  output logic                     dut_reset,
  output logic                     dut_start,
  input  logic                     dut_done,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [RUN_W-1:0]         res_index,
  output logic [1:0]               res_status,
  output logic [CYCLE_W-1:0]       res_cycles,
  output logic                     busy,
  output logic                     batch_done,
  output logic [CYCLE_W-1:0]       stat_min,
  output logic [CYCLE_W-1:0]       stat_max,
  output logic [CYCLE_W+RUN_W-1:0] stat_total
);

  localparam logic [CYCLE_W-1:0] TO       = CYCLE_W'(TIMEOUT_CYCLES);
  localparam int                 RST_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0]   RST_LAST = RST_W'(RST_CYCLES - 1);

  state_e             state;
  logic [RUN_W-1:0]   num_q;
  logic [RUN_W-1:0]   run_idx;
  logic [CYCLE_W-1:0] cnt;
  logic [RST_W-1:0]   rst_cnt;

  logic xfer, stats_clr, stats_upd, last_run;

  assign xfer      = (state == S_REPORT) && res_valid && res_ready;
  assign stats_clr = (state == S_IDLE) && go;
  assign stats_upd = xfer && (res_status == ST_OK);
  assign last_run  = (run_idx == num_q - 1'b1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      num_q      <= '0;
      run_idx    <= '0;
      cnt        <= '0;
      rst_cnt    <= '0;
      dut_reset  <= 1'b0;
      dut_start  <= 1'b0;
      res_valid  <= 1'b0;
      res_index  <= '0;
      res_status <= '0;
      res_cycles <= '0;
      busy       <= 1'b0;
      batch_done <= 1'b0;
    end else begin
      dut_start  <= 1'b0;
      batch_done <= 1'b0;
      case (state)
        S_IDLE: begin
          dut_reset <= 1'b1;
          if (go) begin
            num_q   <= num_runs;
            run_idx <= '0;
            busy    <= 1'b1;
            if (num_runs == '0) begin
              state      <= S_FINISH;
              batch_done <= 1'b1;
            end else begin
              state     <= S_DRST;
              dut_reset <= 1'b0;
              rst_cnt   <= '0;
            end
          end
        end

        S_DRST: begin
          if (rst_cnt == RST_LAST) begin
            state     <= S_START;
            dut_reset <= 1'b1;
            dut_start <= 1'b1;
            cnt       <= CYCLE_W'(1);   // the start cycle counts as latency 1
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end

        S_START: begin
          if (dut_done) begin
            state      <= S_REPORT;
            res_valid  <= 1'b1;
            res_index  <= run_idx;
            res_status <= ST_OK;
            res_cycles <= cnt;
          end else begin
            state <= S_WAIT;
            if (cnt != TO) cnt <= cnt + 1'b1;
          end
        end

        // done is checked first so a done landing on the timeout cycle wins
        S_WAIT: begin
          if (dut_done) begin
            state      <= S_REPORT;
            res_valid  <= 1'b1;
            res_index  <= run_idx;
            res_status <= ST_OK;
            res_cycles <= cnt;
          end else if (cnt == TO) begin
            state      <= S_REPORT;
            res_valid  <= 1'b1;
            res_index  <= run_idx;
            res_status <= ST_TIMEOUT;
            res_cycles <= TO;
            dut_reset  <= 1'b0;         // park a hung accelerator in reset
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // fields are frozen here; dut_done is ignored until the next run
        S_REPORT: begin
          if (xfer) begin
            res_valid <= 1'b0;
            run_idx   <= run_idx + 1'b1;
            if ((ABORT_ON_TIMEOUT && res_status == ST_TIMEOUT) || last_run) begin
              state      <= S_FINISH;
              batch_done <= 1'b1;
            end else begin
              state     <= S_DRST;
              dut_reset <= 1'b0;
              rst_cnt   <= '0;
            end
          end
        end

        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  hls_latency_stats #(
    .CYCLE_W (CYCLE_W),
    .RUN_W   (RUN_W)
  ) u_stats (
    .clock      (clock),
    .reset      (reset),
    .clear      (stats_clr),
    .update     (stats_upd),
    .sample     (res_cycles),
    .stat_min   (stat_min),
    .stat_max   (stat_max),
    .stat_total (stat_total)
  );

endmodule

// File: tb/tb_hls_run_sequencer.sv
module tb_hls_run_sequencer;
  import hls_tb_pkg::*;

  localparam int CW = 32;
  localparam int RW = 8;
  localparam int TO = 50;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          sel   = 1'b0;   // 0: abort-on-timeout instance, 1: continue instance
  logic          go    = 1'b0;
  logic          rdy   = 1'b0;
  logic [RW-1:0] num_runs = '0;
  int            done_dly = -1;  // -1 never, 0 same cycle as start, N cycles after start

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  logic go_a, go_b, rdy_a, rdy_b, done_a, done_b;
  logic dreset_a, dreset_b, start_a, start_b, valid_a, valid_b;
  logic busy_a, busy_b, bdone_a, bdone_b;
  logic [RW-1:0] index_a, index_b;
  logic [1:0]    status_a, status_b;
  logic [CW-1:0] cycles_a, cycles_b, min_a, min_b, max_a, max_b;
  logic [CW+RW-1:0] total_a, total_b;

  logic m_valid, m_busy, m_bdone, m_dreset, m_start, done_src, done_reg;
  logic [RW-1:0]    m_index;
  logic [1:0]       m_status;
  logic [CW-1:0]    m_cycles, m_min, m_max;
  logic [CW+RW-1:0] m_total;

  assign go_a   = go  & ~sel;
  assign go_b   = go  &  sel;
  assign rdy_a  = rdy & ~sel;
  assign rdy_b  = rdy &  sel;
  assign done_a = done_src & ~sel;
  assign done_b = done_src &  sel;

  assign m_valid  = sel ? valid_b  : valid_a;
  assign m_busy   = sel ? busy_b   : busy_a;
  assign m_bdone  = sel ? bdone_b  : bdone_a;
  assign m_dreset = sel ? dreset_b : dreset_a;
  assign m_start  = sel ? start_b  : start_a;
  assign m_index  = sel ? index_b  : index_a;
  assign m_status = sel ? status_b : status_a;
  assign m_cycles = sel ? cycles_b : cycles_a;
  assign m_min    = sel ? min_b    : min_a;
  assign m_max    = sel ? max_b    : max_a;
  assign m_total  = sel ? total_b  : total_a;

  hls_run_sequencer #(.CYCLE_W(CW), .RUN_W(RW), .TIMEOUT_CYCLES(TO),
                      .RST_CYCLES(2), .ABORT_ON_TIMEOUT(1'b1)) dut_a (
    .clock(clock), .reset(reset), .go(go_a), .num_runs(num_runs),
    .dut_reset(dreset_a), .dut_start(start_a), .dut_done(done_a),
    .res_valid(valid_a), .res_ready(rdy_a), .res_index(index_a),
    .res_status(status_a), .res_cycles(cycles_a), .busy(busy_a),
    .batch_done(bdone_a), .stat_min(min_a), .stat_max(max_a), .stat_total(total_a));

  hls_run_sequencer #(.CYCLE_W(CW), .RUN_W(RW), .TIMEOUT_CYCLES(TO),
                      .RST_CYCLES(2), .ABORT_ON_TIMEOUT(1'b0)) dut_b (
    .clock(clock), .reset(reset), .go(go_b), .num_runs(num_runs),
    .dut_reset(dreset_b), .dut_start(start_b), .dut_done(done_b),
    .res_valid(valid_b), .res_ready(rdy_b), .res_index(index_b),
    .res_status(status_b), .res_cycles(cycles_b), .busy(busy_b),
    .batch_done(bdone_b), .stat_min(min_b), .stat_max(max_b), .stat_total(total_b));

  // accelerator model: done one cycle wide, done_dly cycles after the start cycle
  int tcnt = 0;
  assign done_src = (done_dly == 0) ? m_start : done_reg;
  always @(posedge clock) begin
    if (m_start) begin
      tcnt     <= 1;
      done_reg <= (done_dly == 1);
    end else if (tcnt > 0 && tcnt < done_dly) begin
      tcnt     <= tcnt + 1;
      done_reg <= (tcnt + 1 == done_dly);
    end else begin
      tcnt     <= 0;
      done_reg <= 1'b0;
    end
  end

  // free-running event counters; checks use differences against snapshots
  int start_cnt = 0, bdone_cnt = 0, rstlow_cnt = 0;
  always @(posedge clock) begin
    if (m_start) start_cnt <= start_cnt + 1;
    if (m_bdone) bdone_cnt <= bdone_cnt + 1;
    if (m_busy && !m_dreset) rstlow_cnt <= rstlow_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!m_valid && n < 300) begin @(negedge clock); n++; end
    chk({tag, " valid"}, 64'(m_valid), 64'd1);
  endtask

  task automatic take(input string tag, input int idx, input int st, input int cyc);
    wait_valid(tag);
    chk({tag, " index"},  64'(m_index),  64'(idx));
    chk({tag, " status"}, 64'(m_status), 64'(st));
    chk({tag, " cycles"}, 64'(m_cycles), 64'(cyc));
    rdy = 1'b1;
    @(negedge clock);
    rdy = 1'b0;
  endtask

  task automatic wait_bdone(input string tag);
    int n = 0;
    while (!m_bdone && n < 300) begin @(negedge clock); n++; end
    chk({tag, " batch_done"}, 64'(m_bdone), 64'd1);
  endtask

  task automatic pulse_go(input int n);
    num_runs = RW'(n);
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " dut_reset"},  64'(m_dreset), 64'd0);
    chk({tag, " dut_start"},  64'(m_start),  64'd0);
    chk({tag, " res_valid"},  64'(m_valid),  64'd0);
    chk({tag, " res_index"},  64'(m_index),  64'd0);
    chk({tag, " res_status"}, 64'(m_status), 64'd0);
    chk({tag, " res_cycles"}, 64'(m_cycles), 64'd0);
    chk({tag, " busy"},       64'(m_busy),   64'd0);
    chk({tag, " batch_done"}, 64'(m_bdone),  64'd0);
    chk({tag, " stat_min"},   64'(m_min),    64'hFFFF_FFFF);
    chk({tag, " stat_max"},   64'(m_max),    64'd0);
    chk({tag, " stat_total"}, 64'(m_total),  64'd0);
  endtask

  initial begin
    int s0, b0, r0, n;
    logic stable;

    // reset state
    repeat (3) @(negedge clock);
    chk_reset_vals("rst");
    reset = 1'b1;
    @(negedge clock);
    chk("idle dut_reset", 64'(m_dreset), 64'd1);

    // three OK runs, done 10 cycles after start -> latency 11
    done_dly = 10;
    s0 = start_cnt; b0 = bdone_cnt; r0 = rstlow_cnt;
    pulse_go(3);
    chk("b3 busy", 64'(m_busy), 64'd1);
    take("b3 r0", 0, 0, 11);
    take("b3 r1", 1, 0, 11);
    take("b3 r2", 2, 0, 11);
    wait_bdone("b3");
    chk("b3 min",   64'(m_min),   64'd11);
    chk("b3 max",   64'(m_max),   64'd11);
    chk("b3 total", 64'(m_total), 64'd33);
    chk("b3 starts", 64'(start_cnt - s0), 64'd3);
    chk("b3 reset-low cycles", 64'(rstlow_cnt - r0), 64'd6);
    @(negedge clock);
    chk("b3 busy end", 64'(m_busy), 64'd0);
    chk("b3 bdone pulses", 64'(bdone_cnt - b0), 64'd1);

    // done in the start cycle -> latency 1
    done_dly = 0;
    pulse_go(1);
    take("same", 0, 0, 1);
    wait_bdone("same");
    chk("same min",   64'(m_min),   64'd1);
    chk("same max",   64'(m_max),   64'd1);
    chk("same total", 64'(m_total), 64'd1);
    @(negedge clock);

    // back-pressure: record held 20 cycles, go while busy ignored
    done_dly = 5;
    pulse_go(2);
    wait_valid("bp");
    s0 = start_cnt;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin num_runs = 8'd7; go = 1'b1; end
      if (i == 6) go = 1'b0;
      @(negedge clock);
      if (!(m_valid && m_index == '0 && m_status == 2'd0 && m_cycles == 32'd6 && m_dreset))
        stable = 1'b0;
    end
    chk("bp stable", 64'(stable), 64'd1);
    chk("bp no new start", 64'(start_cnt - s0), 64'd0);
    take("bp r0", 0, 0, 6);
    take("bp r1", 1, 0, 6);
    wait_bdone("bp");
    chk("bp max",   64'(m_max),   64'd6);
    chk("bp total", 64'(m_total), 64'd12);
    @(negedge clock);

    // zero runs -> batch_done the cycle after go, no start
    s0 = start_cnt;
    num_runs = '0;
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    chk("zero batch_done", 64'(m_bdone), 64'd1);
    @(negedge clock);
    chk("zero pulse end", 64'(m_bdone), 64'd0);
    chk("zero starts", 64'(start_cnt - s0), 64'd0);

    // timeout with abort: one record, accelerator parked in reset
    done_dly = -1;
    s0 = start_cnt;
    pulse_go(4);
    wait_valid("abort");
    chk("abort dut_reset low", 64'(m_dreset), 64'd0);
    take("abort r0", 0, 1, TO);
    wait_bdone("abort");
    chk("abort no more rec", 64'(m_valid), 64'd0);
    chk("abort dut_reset held", 64'(m_dreset), 64'd0);
    chk("abort starts", 64'(start_cnt - s0), 64'd1);
    chk("abort min", 64'(m_min), 64'hFFFF_FFFF);
    chk("abort max", 64'(m_max), 64'd0);
    @(negedge clock);

    // timeout without abort: four timeout records
    sel = 1'b1;
    @(negedge clock);
    pulse_go(4);
    take("cont r0", 0, 1, TO);
    take("cont r1", 1, 1, TO);
    take("cont r2", 2, 1, TO);
    take("cont r3", 3, 1, TO);
    wait_bdone("cont");
    chk("cont min",   64'(m_min),   64'hFFFF_FFFF);
    chk("cont max",   64'(m_max),   64'd0);
    chk("cont total", 64'(m_total), 64'd0);
    @(negedge clock);
    sel = 1'b0;
    @(negedge clock);

    // reset pulled during WAIT, then a clean batch
    done_dly = 10;
    pulse_go(2);
    take("mid r0", 0, 0, 11);
    done_dly = -1;
    n = 0;
    while (!m_start && n < 50) begin @(negedge clock); n++; end
    chk("mid second start", 64'(m_start), 64'd1);
    repeat (10) @(negedge clock);
    chk("mid busy", 64'(m_busy), 64'd1);
    reset = 1'b0;
    #1;
    chk_reset_vals("mid");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    done_dly = 10;
    pulse_go(1);
    take("post r0", 0, 0, 11);
    wait_bdone("post");
    chk("post min",   64'(m_min),   64'd11);
    chk("post total", 64'(m_total), 64'd11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
